usb_tx: RTL
===========

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 8, giving clocks per USB bit time.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 64, giving the maximum data bytes per DATA packet.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port tx_packet, input, 3 bits: 0=none, 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL, 6/7=invalid.
REQ-006 SHALL have port buffer_occupancy, input, 7 bits: bytes held in the TX FIFO.
REQ-007 SHALL have port tx_packet_data, input, 8 bits: FIFO head byte, valid combinationally.
REQ-008 SHALL have port get_tx_packet_data, output, 1 bit: one-cycle pop strobe.
REQ-009 SHALL have port tx_transfer_active, output, 1 bit: high while a packet is on the bus.
REQ-010 SHALL have port tx_error, output, 1 bit: one-cycle error pulse.
REQ-011 SHALL have ports d_plus_out and d_minus_out, outputs, 1 bit each: the bus line drive.

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, PID, LOAD, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
REQ-013 IDLE SHALL drive J (d_plus_out=1, d_minus_out=0); a nonzero tx_packet sampled in IDLE starts a packet.
REQ-014 tx_packet SHALL be ignored when not in IDLE.
REQ-015 Start latency SHALL be: tx_packet sampled at edge N; the first SYNC bit is on the lines after edge N+1; tx_transfer_active rises at edge N+1.
REQ-016 Each bit SHALL hold exactly BIT_PERIOD clocks; a bit-phase counter wraps from BIT_PERIOD-1 to 0 at each bit boundary.
REQ-017 Bytes SHALL be sent LSB first; SYNC=0x80, PID bytes DATA0=0xC3, DATA1=0x4B, ACK=0xD2, NAK=0x5A, STALL=0x1E.
REQ-018 Encoding SHALL be NRZI: a 0 bit toggles both lines and a 1 bit holds them.
REQ-019 Bit stuffing SHALL apply: after six consecutive 1 bits from the SYNC last bit onward, one inserted 0 bit follows, and the ones count clears.
REQ-020 Stuffing SHALL also apply across CRC bits and SHALL NOT apply during EOP.
REQ-021 For DATA0/DATA1, the byte count SHALL be latched from buffer_occupancy at the start cycle.
REQ-022 If the latched count exceeds MAX_PAYLOAD, the block SHALL pulse tx_error, send nothing, and stay IDLE.
REQ-023 For each payload byte, get_tx_packet_data SHALL pulse exactly one cycle in LOAD, and tx_packet_data SHALL be captured on that same edge.
REQ-024 The LOAD pulse SHALL occur within the last bit of the previous byte, so there are no gaps between bytes.
REQ-025 A zero-length DATA packet SHALL send PID then CRC directly.
REQ-026 Handshake packets SHALL go PID then EOP and SHALL never pulse get_tx_packet_data.
REQ-027 EOP SHALL be 2 bit periods of SE0 (both lines 0) followed by 1 bit period of J.
REQ-028 tx_transfer_active SHALL fall on the edge that ends EOP_J, and the FSM returns to IDLE on that edge.
REQ-029 tx_packet of 6 or 7 sampled in IDLE SHALL pulse tx_error for one cycle and send nothing.
REQ-030 tx_error SHALL never assert during a transmission.
REQ-031 A packet may be accepted on the cycle immediately after returning to IDLE, giving back-to-back packets.

Reset
REQ-032 When rst is high at an edge, the FSM SHALL go to IDLE and the counters and CRC register SHALL clear.
REQ-033 Reset output values SHALL be d_plus_out=1, d_minus_out=0, tx_transfer_active=0, tx_error=0, get_tx_packet_data=0.
REQ-034 Reset mid-packet SHALL abort immediately with no EOP sent, and the lines SHALL return to J on the next edge.

Configuration
REQ-035 Macro USB_TX_CRC16_EN SHALL control CRC generation.
REQ-036 With USB_TX_CRC16_EN defined, DATA packets SHALL append CRC-16 (poly 0x8005, init 0xFFFF, over payload bits LSB first, complemented) as 2 bytes, low byte first.
REQ-037 Without USB_TX_CRC16_EN, the CRC_LO and CRC_HI states SHALL be removed and DATA packets SHALL go from payload straight to EOP.

Verification
REQ-038 ACK scenario: tx_packet=3 for one cycle -> lines follow SYNC+0xD2 NRZI, then 2-bit SE0 and 1-bit J; tx_transfer_active SHALL be high for exactly 152 clocks.
REQ-039 Zero-length DATA0 scenario: buffer_occupancy=0, tx_packet=1 -> SYNC, 0xC3, CRC 0x00 0x00 (with CRC enabled), EOP; get_tx_packet_data SHALL never pulse.
REQ-040 64-byte DATA1 scenario: 64 bytes of 0xFF -> 64 get_tx_packet_data pulses, a stuffed 0 after every six 1s, and no inter-byte gap.
REQ-041 Overflow scenario: buffer_occupancy=65, tx_packet=1 -> one-cycle tx_error, lines stay J, tx_transfer_active stays 0.
REQ-042 Invalid-code scenario: tx_packet=7 -> one-cycle tx_error; a following tx_packet=4 SHALL send a correct NAK.
REQ-043 Reset-abort scenario: rst raised at bit 5 of a DATA0 PID -> next edge has lines J, tx_transfer_active=0, FSM in IDLE.

Source files
------------

// File: rtl/usb_tx.sv
// usb_tx: USB packet transmitter (SYNC, PID, payload, EOP) with NRZI encoding and bit stuffing.
// Define USB_TX_CRC16_EN to append a CRC-16 to DATA packets; the default build sends none.
module usb_tx #(
  parameter int BIT_PERIOD  = 8,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       d_plus_out,
  output logic       d_minus_out
);
  localparam int PW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, LOAD, DATA,
`ifdef USB_TX_CRC16_EN
    CRC_LO, CRC_HI,
`endif
    EOP_SE0, EOP_J
  } state_t;

  state_t        r_state;
  state_t        w_end_st;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_idx;
  logic [2:0]    r_ones;
  logic [7:0]    r_shift;
  logic [7:0]    r_nxt;
  logic [7:0]    r_pid;
  logic [6:0]    r_left;
  logic          r_have;
  logic          r_pend;
  logic          r_data;
  logic          r_dp;
  logic          r_dm;
  logic          r_active;
  logic          r_err;
  logic          r_get;
  logic          w_bnd;
  logic          w_bad;
  logic          w_isdata;
  logic          w_ovf;
  logic          w_start;
  logic          w_stuff;
  logic          w_last;
  logic          w_more;
  logic          w_nbit;
  logic          w_go_eop;
  logic [7:0]    w_pid;
  logic [7:0]    w_nbyte;

  assign w_bad    = tx_packet[2] & tx_packet[1];
  assign w_isdata = tx_packet == 3'd1 || tx_packet == 3'd2;
  assign w_ovf    = w_isdata && ({1'b0, buffer_occupancy} > MAXP);
  assign w_start  = tx_packet != 3'd0 && !w_bad && !w_ovf;
  assign w_pid    = tx_packet == 3'd1 ? 8'hC3 :
                    tx_packet == 3'd2 ? 8'h4B :
                    tx_packet == 3'd3 ? 8'hD2 :
                    tx_packet == 3'd4 ? 8'h5A : 8'h1E;

  // The bit on the wire is (r_state, r_idx); each boundary picks the next one or a stuffed 0.
  assign w_bnd    = r_phase == PH_LAST;
  assign w_stuff  = r_ones == 3'd6;
  assign w_last   = r_idx == 3'd7;
  assign w_more   = r_state == DATA && r_have;
  assign w_nbit   = w_stuff ? 1'b0 : w_last ? w_nbyte[0] : r_shift[r_idx + 3'd1];
  assign w_go_eop = w_last && !w_stuff && w_end_st == EOP_SE0;

`ifdef USB_TX_CRC16_EN
  logic [15:0] r_crc;
  logic        w_pay;
  assign w_pay    = !w_stuff && (w_last ? w_more : r_state == DATA);
  assign w_end_st = r_state == SYNC ? PID : w_more ? DATA : r_state == CRC_LO ? CRC_HI :
                    (r_state == CRC_HI || !r_data) ? EOP_SE0 : CRC_LO;
  assign w_nbyte  = r_state == SYNC ? r_pid : w_more ? r_nxt :
                    r_state == CRC_LO ? ~r_crc[15:8] : ~r_crc[7:0];
  // Reflected form of poly 0x8005: the complemented register goes out LSB first.
  always_ff @(posedge clk) begin
    if (rst)
      r_crc <= '0;
    else if (r_state == IDLE)
      r_crc <= 16'hFFFF;
    else if (w_bnd && w_pay && r_state != EOP_SE0 && r_state != EOP_J)
      r_crc <= {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_nbit) ? 16'hA001 : 16'h0000);
  end
`else
  assign w_end_st = r_state == SYNC ? PID : w_more ? DATA : EOP_SE0;
  assign w_nbyte  = r_state == SYNC ? r_pid : r_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_idx    <= '0;
      r_ones   <= '0;
      r_shift  <= '0;
      r_nxt    <= '0;
      r_pid    <= '0;
      r_left   <= '0;
      r_have   <= 1'b0;
      r_pend   <= 1'b0;
      r_data   <= 1'b0;
      r_dp     <= 1'b1;
      r_dm     <= 1'b0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_get    <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_get   <= 1'b0;
      r_phase <= (r_state == IDLE || w_bnd) ? '0 : r_phase + 1'b1;
      if (r_state == IDLE) begin
        if (r_pend) begin
          r_pend   <= 1'b0;
          r_state  <= SYNC;
          r_active <= 1'b1;
          r_idx    <= '0;
          r_ones   <= '0;
          r_shift  <= 8'h80;
          r_dp     <= 1'b0;
          r_dm     <= 1'b1;
        end else if (w_start) begin
          r_pend <= 1'b1;
          r_pid  <= w_pid;
          r_data <= w_isdata;
          r_left <= w_isdata ? buffer_occupancy : '0;
          r_have <= 1'b0;
        end else begin
          r_err <= w_bad || w_ovf;
        end
      end else if (r_state == LOAD) begin
        r_nxt   <= tx_packet_data;
        r_have  <= 1'b1;
        r_state <= DATA;
      end else if (r_state == EOP_SE0) begin
        if (w_bnd) begin
          r_idx <= r_idx + 3'd1;
          if (r_idx[0]) begin
            r_state <= EOP_J;
            r_dp    <= 1'b1;
          end
        end
      end else if (r_state == EOP_J) begin
        if (w_bnd) begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      end else if (w_bnd) begin
        if (w_go_eop) begin
          r_state <= EOP_SE0;
          r_idx   <= '0;
          r_ones  <= '0;
          r_dp    <= 1'b0;
          r_dm    <= 1'b0;
        end else begin
          r_ones <= w_nbit ? r_ones + 3'd1 : '0;
          if (!w_nbit) begin
            r_dp <= ~r_dp;
            r_dm <= ~r_dm;
          end
          if (!w_stuff) begin
            r_idx <= r_idx + 3'd1;
            if (w_last) begin
              r_state <= w_end_st;
              r_shift <= w_nbyte;
              r_have  <= 1'b0;
            end else if (r_idx == 3'd6 && (r_state == PID || r_state == DATA) && r_left != '0) begin
              r_state <= LOAD;
              r_get   <= 1'b1;
              r_left  <= r_left - 7'd1;
            end
          end
        end
      end
    end
  end

  assign get_tx_packet_data = r_get;
  assign tx_transfer_active = r_active;
  assign tx_error           = r_err;
  assign d_plus_out         = r_dp;
  assign d_minus_out        = r_dm;
endmodule
